// File: rtl/iq_multi_pkg.sv
// Shared constants for the multi-lane instruction queue.
// Contents:
//   IQ_XLEN   default instruction/PC width
//   QUE_SIZE  default queue depth
//   NOP_INST  canonical NOP encoding (addi x0, x0, 0)
//   `IQ_LANE  selects lane i of a lane-packed vector (lane i at [i*w +: w])
//   lane_fits helper: true when a lane index names a real lane
// Optional feature macro used elsewhere in this slice: IQ_BYPASS_EN.
`ifndef IQ_MULTI_PKG_SV
`define IQ_MULTI_PKG_SV
`define IQ_LANE(vec, i, w) vec[(i)*(w) +: (w)]

package iq_multi_pkg;
  localparam int IQ_XLEN = 32;
  localparam int QUE_SIZE = 16;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  // Shifted lane selection (bypass) can name a lane past the last one.
  function automatic logic lane_fits(input int lane, input int lanes);
    return (lane >= 0) && (lane < lanes);
  endfunction
endpackage
`endif

// File: rtl/iq_multi_if.sv
// Fetch-side and issue-side signals of the instruction queue.
// Handshake rules:
//   enq_valid[i]  lane i carries an instruction this cycle; lanes are
//                 contiguous. There is no per-lane ready: the producer
//                 must stop when full is high, anything pushed beyond the
//                 free space is dropped and flagged by the queue.
//   issue_valid/issue_ready  a transfer happens on a clock edge where both
//                 are high (and the queue is enabled); issue_inst/issue_pc
//                 are stable while issue_valid is high and not accepted.
//   flush         discards every stored entry.
// Modports: master = fetch/issue environment, slave = the queue.
interface iq_multi_if
  import iq_multi_pkg::*;
#(
  parameter int ENQ_W = 2,
  parameter int XLEN  = IQ_XLEN
);
  logic [ENQ_W-1:0]      enq_valid;
  logic [ENQ_W*XLEN-1:0] enq_inst;
  logic [ENQ_W*XLEN-1:0] enq_pc;
  logic                  full;
  logic                  flush;
  logic                  issue_valid;
  logic                  issue_ready;
  logic [XLEN-1:0]       issue_inst;
  logic [XLEN-1:0]       issue_pc;

  modport master (
    output enq_valid, enq_inst, enq_pc, flush, issue_ready,
    input  full, issue_valid, issue_inst, issue_pc
  );

  modport slave (
    input  enq_valid, enq_inst, enq_pc, flush, issue_ready,
    output full, issue_valid, issue_inst, issue_pc
  );
endinterface

// File: rtl/iq_multi_ram.sv
// Queue storage: DEPTH entries of {pc, inst}.
// Ports:
//   clk    clock
//   we     per-port write enable (NPORT synchronous write ports)
//   waddr  per-port write address
//   wdata  per-port write data {pc, inst}
//   raddr  asynchronous read address
//   rdata  asynchronous read data
// The array has no reset; contents are meaningless until written.
module iq_multi_ram
  import iq_multi_pkg::*;
#(
  parameter int DEPTH = QUE_SIZE,
  parameter int DW    = 2 * IQ_XLEN,
  parameter int NPORT = 2,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic [NPORT-1:0]          we,
  input  logic [NPORT-1:0][AW-1:0]  waddr,
  input  logic [NPORT-1:0][DW-1:0]  wdata,
  input  logic [AW-1:0]             raddr,
  output logic [DW-1:0]             rdata
);
  logic [DW-1:0] mem [DEPTH];

  // The controller never enables two ports on the same address.
  always_ff @(posedge clk) begin
    for (int p = 0; p < NPORT; p++) begin
      if (we[p]) mem[waddr[p]] <= wdata[p];
    end
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/iq_multi.sv
// Multi-lane instruction queue between instruction fetch and issue.
// Accepts up to ENQ_W instructions per cycle into a power-of-two circular
// buffer and presents the head entry show-ahead on a valid/ready port.
// Ports:
//   clk, rst  clock, synchronous active-high reset
//   rdy       global enable; low freezes all state
//   bus       iq_multi_if.slave: enq_*, full, flush, issue_*
//   count     occupancy, 0..DEPTH
//   ovf_err   sticky: a push arrived with no free slot
// Optional feature: define IQ_BYPASS_EN to let an instruction arriving at
// an empty queue issue in the same cycle.
module iq_multi
  import iq_multi_pkg::*;
#(
  parameter int DEPTH = QUE_SIZE,
  parameter int ENQ_W = 2,
  parameter int SLACK = 1,
  parameter int XLEN  = IQ_XLEN
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rdy,
  iq_multi_if.slave              bus,
  output logic [$clog2(DEPTH):0] count,
  output logic                   ovf_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] head, tail;
  logic          full_q, full_next;
  logic [CW-1:0] free_slots, n_req, n_push, count_next;
  logic          pop, byp_valid, byp_take, ovf_now;

  logic [ENQ_W-1:0]             we;
  logic [ENQ_W-1:0][AW-1:0]     waddr;
  logic [ENQ_W-1:0][2*XLEN-1:0] wdata;
  logic [2*XLEN-1:0]            rdata;

  always_comb begin
    int src;
    byp_valid = 1'b0;
`ifdef IQ_BYPASS_EN
    byp_valid = (count == '0) && bus.enq_valid[0] && !bus.flush;
`endif
    // A bypassed lane 0 is consumed straight from the input and never stored.
    byp_take = byp_valid && bus.issue_ready && rdy;
    pop      = (count != '0) && bus.issue_ready && rdy && !bus.flush;

    n_req = '0;
    for (int i = 0; i < ENQ_W; i++) begin
      if (bus.enq_valid[i]) n_req = n_req + CW'(1);
    end
    if (byp_take) n_req = n_req - CW'(1);

    // Free space is taken before this cycle's pop: a full queue drops
    // pushes even while it is being drained.
    free_slots = CW'(DEPTH) - count;
    n_push     = (n_req > free_slots) ? free_slots : n_req;
    ovf_now    = rdy && !bus.flush && (n_req > free_slots);

    count_next = count + n_push - CW'(pop);
    if (bus.flush) count_next = '0;
    full_next = (DEPTH - int'(count_next)) < (ENQ_W + SLACK);

    src = 0;
    for (int j = 0; j < ENQ_W; j++) begin
      src      = j + (byp_take ? 1 : 0);
      we[j]    = rdy && !bus.flush && (CW'(j) < n_push);
      waddr[j] = tail + AW'(j);
      wdata[j] = '0;
      if (lane_fits(src, ENQ_W)) begin
        wdata[j] = {`IQ_LANE(bus.enq_pc, src, XLEN), `IQ_LANE(bus.enq_inst, src, XLEN)};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      full_q  <= 1'b0;
      ovf_err <= 1'b0;
    end else if (rdy) begin
      if (bus.flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        head  <= head + AW'(pop);
        tail  <= tail + n_push[AW-1:0];
        count <= count_next;
      end
      full_q <= full_next;
      if (ovf_now) ovf_err <= 1'b1;
    end
  end

  iq_multi_ram #(
    .DEPTH (DEPTH),
    .DW    (2 * XLEN),
    .NPORT (ENQ_W)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (head),
    .rdata (rdata)
  );

  assign bus.full        = full_q;
  assign bus.issue_valid = (count != '0) || byp_valid;

  always_comb begin
    bus.issue_inst = '0;
    bus.issue_pc   = '0;
    if (count != '0) begin
      bus.issue_inst = rdata[XLEN-1:0];
      bus.issue_pc   = rdata[2*XLEN-1:XLEN];
    end else if (byp_valid) begin
      bus.issue_inst = `IQ_LANE(bus.enq_inst, 0, XLEN);
      bus.issue_pc   = `IQ_LANE(bus.enq_pc, 0, XLEN);
    end
  end
endmodule

// File: tb/tb_iq_multi.sv
// Directed testbench for iq_multi (DEPTH=16, ENQ_W=2, SLACK=1, XLEN=32).
module tb_iq_multi;
  localparam int DEPTH = 16;
  localparam int ENQ_W = 2;
  localparam int SLACK = 1;
  localparam int XLEN  = 32;

  logic       clk;
  logic       rst;
  logic       rdy;
  logic [4:0] count;
  logic       ovf_err;

  int errors = 0;
  int checks = 0;

  logic [XLEN-1:0] exp_q[$];

  iq_multi_if #(.ENQ_W(ENQ_W), .XLEN(XLEN)) bus ();

  iq_multi #(
    .DEPTH (DEPTH),
    .ENQ_W (ENQ_W),
    .SLACK (SLACK),
    .XLEN  (XLEN)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .rdy     (rdy),
    .bus     (bus),
    .count   (count),
    .ovf_err (ovf_err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [XLEN-1:0] inst_of(input logic [XLEN-1:0] pc);
    return pc ^ 32'hA5A5_0013;
  endfunction

  task automatic set_enq(input logic [1:0] v, input logic [XLEN-1:0] pc0,
                         input logic [XLEN-1:0] pc1);
    bus.enq_valid = v;
    bus.enq_pc    = {pc1, pc0};
    bus.enq_inst  = {inst_of(pc1), inst_of(pc0)};
  endtask

  task automatic idle();
    bus.enq_valid = '0;
    bus.enq_inst  = '0;
    bus.enq_pc    = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rdy = 1'b1;
    bus.flush = 1'b0;
    bus.issue_ready = 1'b0;
    idle();
    tick();
    tick();
    rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", bus.full); end
    checks++; if (bus.issue_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.issue_valid); end
    checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", ovf_err); end
    checks++; if (bus.issue_inst !== 32'h0) begin errors++; $display("FAIL reset_inst got=%h exp=0", bus.issue_inst); end
    checks++; if (bus.issue_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=0", bus.issue_pc); end
  endtask

  task automatic test_single_push();
    logic exp_same;
`ifdef IQ_BYPASS_EN
    exp_same = 1'b1;
`else
    exp_same = 1'b0;
`endif
    do_reset();
    bus.enq_valid = 2'b01;
    bus.enq_inst  = {32'h0, 32'h0050_0093};
    bus.enq_pc    = '0;
    #1;
    checks++; if (bus.issue_valid !== exp_same) begin errors++; $display("FAIL push_same_cycle_valid got=%b exp=%b", bus.issue_valid, exp_same); end
    tick();
    idle();
    #1;
    checks++; if (bus.issue_valid !== 1'b1) begin errors++; $display("FAIL push_valid got=%b exp=1", bus.issue_valid); end
    checks++; if (bus.issue_inst !== 32'h0050_0093) begin errors++; $display("FAIL push_inst got=%h exp=00500093", bus.issue_inst); end
    checks++; if (bus.issue_pc !== 32'h0) begin errors++; $display("FAIL push_pc got=%h exp=0", bus.issue_pc); end
    checks++; if (count !== 5'd1) begin errors++; $display("FAIL push_count got=%0d exp=1", count); end
    bus.issue_ready = 1'b1;
    tick();
    bus.issue_ready = 1'b0;
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL pop_count got=%0d exp=0", count); end
    checks++; if (bus.issue_valid !== 1'b0) begin errors++; $display("FAIL pop_valid got=%b exp=0", bus.issue_valid); end
    checks++; if (bus.issue_inst !== 32'h0) begin errors++; $display("FAIL pop_inst_forced got=%h exp=0", bus.issue_inst); end
  endtask

  task automatic test_fill_overflow();
    do_reset();
    for (int k = 0; k < 8; k++) begin
      set_enq(2'b11, 32'(8 * k), 32'(8 * k + 4));
      tick();
      if (k == 5) begin
        checks++; if (count !== 5'd12) begin errors++; $display("FAIL fill12_count got=%0d exp=12", count); end
        checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL fill12_full got=%b exp=0", bus.full); end
      end
      if (k == 6) begin
        checks++; if (count !== 5'd14) begin errors++; $display("FAIL fill14_count got=%0d exp=14", count); end
        checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL fill14_full got=%b exp=1", bus.full); end
      end
    end
    idle();
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL fill16_count got=%0d exp=16", count); end
    checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL fill16_ovf got=%b exp=0", ovf_err); end
    set_enq(2'b11, 32'h400, 32'h404);
    tick();
    idle();
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL ovf_count got=%0d exp=16", count); end
    checks++; if (ovf_err !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b exp=1", ovf_err); end
    bus.issue_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (bus.issue_pc !== 32'(4 * i) || bus.issue_inst !== inst_of(32'(4 * i))) begin
        errors++; $display("FAIL drain_entry[%0d] got pc=%h inst=%h exp pc=%h", i, bus.issue_pc, bus.issue_inst, 4 * i);
      end
      tick();
    end
    bus.issue_ready = 1'b0;
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL drain_count got=%0d exp=0", count); end
    checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL drain_full got=%b exp=0", bus.full); end
    checks++; if (ovf_err !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", ovf_err); end
  endtask

  task automatic test_stream();
    int sent = 0;
    int recv = 0;
    int cyc = 0;
    logic [XLEN-1:0] exp_pc;
    do_reset();
    exp_q.delete();
    bus.issue_ready = 1'b1;
    while (recv < 40 && cyc < 300) begin
      idle();
      if (sent < 40 && !bus.full) begin
        if ((cyc % 3) == 0 && sent < 39) begin
          set_enq(2'b11, 32'h1000 + 32'(4 * sent), 32'h1000 + 32'(4 * sent + 4));
          exp_q.push_back(32'h1000 + 32'(4 * sent));
          exp_q.push_back(32'h1000 + 32'(4 * sent + 4));
          sent += 2;
        end else begin
          set_enq(2'b01, 32'h1000 + 32'(4 * sent), 32'h0);
          exp_q.push_back(32'h1000 + 32'(4 * sent));
          sent += 1;
        end
      end
      #1;
      if (bus.issue_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL stream_extra got pc=%h exp=none", bus.issue_pc);
        end else begin
          exp_pc = exp_q.pop_front();
          if (bus.issue_pc !== exp_pc || bus.issue_inst !== inst_of(exp_pc)) begin
            errors++; $display("FAIL stream_entry[%0d] got pc=%h inst=%h exp pc=%h", recv, bus.issue_pc, bus.issue_inst, exp_pc);
          end
        end
        recv++;
      end
      tick();
      cyc++;
    end
    idle();
    bus.issue_ready = 1'b0;
    checks++; if (recv !== 40) begin errors++; $display("FAIL stream_total got=%0d exp=40", recv); end
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL stream_count got=%0d exp=0", count); end
  endtask

  task automatic test_flush();
    do_reset();
    set_enq(2'b11, 32'h0, 32'h4); tick();
    set_enq(2'b11, 32'h8, 32'hC); tick();
    set_enq(2'b01, 32'h10, 32'h0); tick();
    idle();
    checks++; if (count !== 5'd5) begin errors++; $display("FAIL flush_pre_count got=%0d exp=5", count); end
    bus.flush = 1'b1;
    bus.issue_ready = 1'b1;
    set_enq(2'b11, 32'h600, 32'h604);
    tick();
    bus.flush = 1'b0;
    bus.issue_ready = 1'b0;
    idle();
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL flush_count got=%0d exp=0", count); end
    checks++; if (bus.issue_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got=%b exp=0", bus.issue_valid); end
    checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL flush_ovf got=%b exp=0", ovf_err); end
    set_enq(2'b01, 32'h700, 32'h0);
    tick();
    idle();
    checks++; if (count !== 5'd1) begin errors++; $display("FAIL post_flush_count got=%0d exp=1", count); end
    checks++; if (bus.issue_pc !== 32'h700) begin errors++; $display("FAIL post_flush_pc got=%h exp=700", bus.issue_pc); end
  endtask

  task automatic test_rdy_freeze();
    do_reset();
    set_enq(2'b11, 32'h200, 32'h204); tick();
    set_enq(2'b01, 32'h208, 32'h0); tick();
    rdy = 1'b0;
    bus.issue_ready = 1'b1;
    set_enq(2'b11, 32'h300, 32'h304);
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (count !== 5'd3 || bus.issue_pc !== 32'h200) begin
        errors++; $display("FAIL freeze[%0d] got count=%0d pc=%h exp count=3 pc=200", i, count, bus.issue_pc);
      end
    end
    rdy = 1'b1;
    idle();
    tick();
    bus.issue_ready = 1'b0;
    checks++; if (count !== 5'd2) begin errors++; $display("FAIL resume_count got=%0d exp=2", count); end
    checks++; if (bus.issue_pc !== 32'h204) begin errors++; $display("FAIL resume_pc got=%h exp=204", bus.issue_pc); end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    for (int k = 0; k < 8; k++) begin
      set_enq(2'b11, 32'(8 * k), 32'(8 * k + 4));
      tick();
    end
    set_enq(2'b01, 32'h500, 32'h0);
    bus.issue_ready = 1'b1;
    tick();
    idle();
    bus.issue_ready = 1'b0;
    checks++; if (count !== 5'd15) begin errors++; $display("FAIL pushpop_count got=%0d exp=15", count); end
    checks++; if (ovf_err !== 1'b1) begin errors++; $display("FAIL pushpop_ovf got=%b exp=1", ovf_err); end
    checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL pushpop_full got=%b exp=1", bus.full); end
    bus.issue_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      checks++;
      if (bus.issue_pc !== 32'(4 + 4 * i)) begin
        errors++; $display("FAIL pushpop_drain[%0d] got=%h exp=%h", i, bus.issue_pc, 4 + 4 * i);
      end
      tick();
    end
    bus.issue_ready = 1'b0;
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL pushpop_empty got=%0d exp=0", count); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_single_push();
    test_fill_overflow();
    test_stream();
    test_flush();
    test_rdy_freeze();
    test_full_push_pop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
